// File: rtl/prog_sequencer.sv
// Run controller for the instruction-fetch stage: launches one program per request,
// holds the core in init for INIT_CYCLES, then runs until Halt or a cycle-count timeout.
module prog_sequencer #(
  parameter int unsigned NUM_PROGS   = 3,
  parameter int unsigned INIT_CYCLES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic        CLK,
  input  logic        Init,
  input  logic        Req,
  input  logic [1:0]  Prog_Sel,
  input  logic        Halt,
  output logic        Core_Init,
  output logic [1:0]  ProgState,
  output logic        Busy,
  output logic        Done,
  output logic        Timeout,
  output logic        Err,
  output logic [15:0] Cycle_Count
);

  localparam int unsigned ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [ICW-1:0]   icnt, icnt_n;
  logic             core_init_n, busy_n, done_n, timeout_n, err_n;
  logic [1:0]       prog_n;
  logic [15:0]      cnt_n;
  logic             sel_valid;

  assign sel_valid = (Prog_Sel != 2'd0) && (32'(Prog_Sel) <= NUM_PROGS);

  always_ff @(posedge CLK) begin
    if (Init) begin
      state       <= S_IDLE;
      icnt        <= '0;
      Core_Init   <= 1'b1;
      ProgState   <= '0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      Timeout     <= 1'b0;
      Err         <= 1'b0;
      Cycle_Count <= '0;
    end else begin
      state       <= state_n;
      icnt        <= icnt_n;
      Core_Init   <= core_init_n;
      ProgState   <= prog_n;
      Busy        <= busy_n;
      Done        <= done_n;
      Timeout     <= timeout_n;
      Err         <= err_n;
      Cycle_Count <= cnt_n;
    end
  end

  always_comb begin
    state_n     = state;
    icnt_n      = icnt;
    core_init_n = Core_Init;
    prog_n      = ProgState;
    busy_n      = Busy;
    done_n      = 1'b0;
    timeout_n   = Timeout;
    err_n       = 1'b0;
    cnt_n       = Cycle_Count;

    unique case (state)
      S_IDLE: begin
        core_init_n = 1'b1;
        if (Req) begin
          if (sel_valid) begin
            prog_n    = Prog_Sel;
            busy_n    = 1'b1;
            timeout_n = 1'b0;
            cnt_n     = '0;
            icnt_n    = ICW'(INIT_CYCLES - 1);
            state_n   = S_INIT;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      S_INIT: begin
        core_init_n = 1'b1;
        if (icnt == '0) begin
          core_init_n = 1'b0;
          state_n     = S_RUN;
        end else begin
          icnt_n = icnt - 1'b1;
        end
      end

      S_RUN: begin
        core_init_n = 1'b0;
        // Halt takes precedence over the timeout on the same edge
        if (Halt) begin
          core_init_n = 1'b1;
          done_n      = 1'b1;
          state_n     = S_DONE;
        end else if (Cycle_Count == 16'(TIMEOUT - 1)) begin
          cnt_n       = 16'(TIMEOUT);
          timeout_n   = 1'b1;
          core_init_n = 1'b1;
          done_n      = 1'b1;
          state_n     = S_DONE;
        end else begin
          cnt_n = Cycle_Count + 16'd1;
        end
      end

      S_DONE: begin
        core_init_n = 1'b1;
        busy_n      = 1'b0;
        state_n     = S_IDLE;
      end

      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: directed and randomized runs checked against a
// transaction-level model of run length, timeout and select validation.
module tb_prog_sequencer;

  localparam int unsigned NP = 3;
  localparam int unsigned IC = 2;
  localparam int unsigned TO = 100;

  logic        CLK = 1'b0;
  logic        Init, Req, Halt;
  logic [1:0]  Prog_Sel;
  logic        Core_Init, Busy, Done, Timeout, Err;
  logic [1:0]  ProgState;
  logic [15:0] Cycle_Count;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [1:0]  exp_prog;
  logic [15:0] exp_cc;
  logic        exp_to;

  prog_sequencer #(
    .NUM_PROGS  (NP),
    .INIT_CYCLES(IC),
    .TIMEOUT    (TO)
  ) dut (
    .CLK        (CLK),
    .Init       (Init),
    .Req        (Req),
    .Prog_Sel   (Prog_Sel),
    .Halt       (Halt),
    .Core_Init  (Core_Init),
    .ProgState  (ProgState),
    .Busy       (Busy),
    .Done       (Done),
    .Timeout    (Timeout),
    .Err        (Err),
    .Cycle_Count(Cycle_Count)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_init"}, 16'(Core_Init), 16'd1);
    chk({tag, "_prog"},      16'(ProgState), 16'd0);
    chk({tag, "_busy"},      16'(Busy), 16'd0);
    chk({tag, "_done"},      16'(Done), 16'd0);
    chk({tag, "_timeout"},   16'(Timeout), 16'd0);
    chk({tag, "_err"},       16'(Err), 16'd0);
    chk({tag, "_cc"},        Cycle_Count, 16'd0);
  endtask

  // One request transaction; h = RUN edges with Halt low before Halt is raised.
  task automatic do_req(input logic [1:0] sel, input int unsigned h, input bit stale_halt);
    bit          valid;
    bit          halts;
    int unsigned n_run;
    valid = (sel != 2'd0) && (int'(sel) <= int'(NP));
    Req = 1'b1; Prog_Sel = sel;
    tick();
    Req = 1'b0;
    if (!valid) begin
      chk("err_pulse", 16'(Err), 16'd1);
      chk("err_busy",  16'(Busy), 16'd0);
      chk("err_prog",  16'(ProgState), 16'(exp_prog));
      chk("err_to",    16'(Timeout), 16'(exp_to));
      tick();
      chk("err_clear", 16'(Err), 16'd0);
      chk("err_cc",    Cycle_Count, exp_cc);
      return;
    end
    exp_prog = sel;
    chk("acc_busy", 16'(Busy), 16'd1);
    chk("acc_prog", 16'(ProgState), 16'(sel));
    chk("acc_to",   16'(Timeout), 16'd0);
    chk("acc_cc",   Cycle_Count, 16'd0);
    chk("acc_ci",   16'(Core_Init), 16'd1);
    chk("acc_err",  16'(Err), 16'd0);
    Halt = stale_halt;
    for (int i = 1; i < int'(IC); i++) begin
      tick();
      chk("init_ci",   16'(Core_Init), 16'd1);
      chk("init_done", 16'(Done), 16'd0);
    end
    tick();
    chk("run_ci_fall", 16'(Core_Init), 16'd0);
    chk("run_done0",   16'(Done), 16'd0);
    Halt = 1'b0;

    halts  = (h < TO);
    n_run  = halts ? h + 1 : TO;
    exp_cc = halts ? 16'(h) : 16'(TO);
    exp_to = !halts;
    for (int unsigned j = 1; j <= n_run; j++) begin
      Halt     = (j == n_run) && halts;
      Req      = 1'($urandom_range(0, 1));
      Prog_Sel = 2'($urandom_range(0, 3));
      tick();
      if (j < n_run) begin
        chk("run_ci",   16'(Core_Init), 16'd0);
        chk("run_done", 16'(Done), 16'd0);
        chk("run_cc",   Cycle_Count, 16'(j));
        chk("run_prog", 16'(ProgState), 16'(sel));
      end
    end
    chk("fin_done", 16'(Done), 16'd1);
    chk("fin_ci",   16'(Core_Init), 16'd1);
    chk("fin_busy", 16'(Busy), 16'd1);
    chk("fin_cc",   Cycle_Count, exp_cc);
    chk("fin_to",   16'(Timeout), 16'(exp_to));
    Halt = 1'b0; Req = 1'b1; Prog_Sel = 2'd1;
    tick();
    Req = 1'b0; Prog_Sel = 2'd0;
    chk("post_done", 16'(Done), 16'd0);
    chk("post_busy", 16'(Busy), 16'd0);
    chk("post_prog", 16'(ProgState), 16'(exp_prog));
    chk("post_cc",   Cycle_Count, exp_cc);
    chk("post_to",   16'(Timeout), 16'(exp_to));
    chk("post_ci",   16'(Core_Init), 16'd1);
  endtask

  initial begin
    Init = 1'b1; Req = 1'b1; Prog_Sel = 2'd2; Halt = 1'b0;
    exp_prog = '0; exp_cc = '0; exp_to = 1'b0;
    repeat (3) begin
      tick();
      chk_reset_vals("rst");
    end
    Init = 1'b0; Req = 1'b0;

    Halt = 1'b1;
    tick();
    chk("idle_halt_done", 16'(Done), 16'd0);
    chk("idle_halt_busy", 16'(Busy), 16'd0);
    Halt = 1'b0;

    do_req(2'd2, 50, 1'b1);
    do_req(2'd0, 0, 1'b0);
    do_req(2'd3, 10, 1'b0);
    do_req(2'd1, 200, 1'b0);
    do_req(2'd2, 5, 1'b0);
    do_req(2'd1, TO - 1, 1'b0);
    do_req(2'd3, 0, 1'b0);

    // Reset while in INIT, with Req held high.
    Req = 1'b1; Prog_Sel = 2'd3;
    tick();
    Init = 1'b1; Prog_Sel = 2'd2;
    repeat (3) begin
      tick();
      chk_reset_vals("rst_init");
    end
    Init = 1'b0; Req = 1'b0;
    exp_prog = '0; exp_cc = '0; exp_to = 1'b0;

    // Reset mid-RUN at Cycle_Count = 20, colliding with Halt.
    Req = 1'b1; Prog_Sel = 2'd2;
    tick();
    Req = 1'b0;
    repeat (IC + 20) tick();
    chk("abort_pre_cc", Cycle_Count, 16'd20);
    Init = 1'b1; Halt = 1'b1;
    tick();
    Init = 1'b0; Halt = 1'b0;
    chk_reset_vals("abort");
    tick();
    chk("abort_no_done", 16'(Done), 16'd0);

    for (int n = 0; n < 15; n++) begin
      do_req(2'($urandom_range(0, 3)), $urandom_range(0, 130), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
